// File: rtl/sparrow_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) vs long-latency writeback (B),
// with a pending-destination scoreboard for RAW/WAW hazard detection.
module sparrow_wb_arbiter #(
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned WAIT_W   = 3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        a_valid_i,
   input  logic [4:0]  a_rd_i,
   input  logic [31:0] a_data_i,
   output logic        a_ready_o,
   input  logic        b_valid_i,
   input  logic [4:0]  b_rd_i,
   input  logic [31:0] b_data_i,
   output logic        b_ready_o,
   input  logic        iss_valid_i,
   input  logic [4:0]  iss_rd_i,
   output logic        iss_ready_o,
   input  logic [4:0]  rs1_addr_i,
   input  logic [4:0]  rs2_addr_i,
   output logic        hazard_o,
   output logic        wr_en_o,
   output logic [4:0]  rd_addr_o,
   output logic [31:0] wr_data_o
);

   typedef enum logic {A_PRIO, B_PRIO} state_t;

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic [31:0]       pending;
   logic [31:0]       pending_nxt;
   logic              a_accept;
   logic              b_accept;
   logic              iss_set;

   always_comb begin
      a_ready_o = 1'b0;
      b_ready_o = 1'b0;
      if (state == A_PRIO) begin
         a_ready_o = a_valid_i;
         b_ready_o = b_valid_i & ~a_valid_i;
      end else begin
         b_ready_o = b_valid_i;
         a_ready_o = a_valid_i & ~b_valid_i;
      end
   end

   assign a_accept    = a_valid_i & a_ready_o;
   assign b_accept    = b_valid_i & b_ready_o;
   assign iss_ready_o = ~pending[iss_rd_i];
   assign iss_set     = iss_valid_i & iss_ready_o & (iss_rd_i != 5'd0);
   assign hazard_o    = pending[rs1_addr_i] | pending[rs2_addr_i];

   // Clear applied before set so a same-cycle issue of the retiring index stays pending.
   always_comb begin
      pending_nxt = pending;
      if (b_accept)
         pending_nxt[b_rd_i] = 1'b0;
      if (iss_set)
         pending_nxt[iss_rd_i] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= A_PRIO;
         wait_cnt  <= '0;
         pending   <= '0;
         wr_en_o   <= 1'b0;
         rd_addr_o <= '0;
         wr_data_o <= '0;
      end else begin
         pending <= pending_nxt;

         case (state)
            A_PRIO: begin
               if (b_valid_i && !b_ready_o) begin
                  wait_cnt <= wait_cnt + 1'b1;
                  if (wait_cnt == WAIT_W'(MAX_WAIT - 1))
                     state <= B_PRIO;
               end else begin
                  wait_cnt <= '0;
               end
            end
            B_PRIO: begin
               if (b_accept || !b_valid_i) begin
                  state    <= A_PRIO;
                  wait_cnt <= '0;
               end
            end
            default: begin
               state    <= A_PRIO;
               wait_cnt <= '0;
            end
         endcase

         wr_en_o <= 1'b0;
         if (a_accept) begin
            wr_en_o   <= (a_rd_i != 5'd0);
            rd_addr_o <= a_rd_i;
            wr_data_o <= a_data_i;
         end else if (b_accept) begin
            wr_en_o   <= (b_rd_i != 5'd0);
            rd_addr_o <= b_rd_i;
            wr_data_o <= b_data_i;
         end
      end
   end

endmodule

// File: tb/tb_sparrow_wb_arbiter.sv
// Directed bench for sparrow_wb_arbiter: arbitration, latency, scoreboard, x0 and reset.
module tb_sparrow_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        a_valid_i, b_valid_i, iss_valid_i;
   logic [4:0]  a_rd_i, b_rd_i, iss_rd_i, rs1_addr_i, rs2_addr_i;
   logic [31:0] a_data_i, b_data_i;
   logic        a_ready_o, b_ready_o, iss_ready_o, hazard_o, wr_en_o;
   logic [4:0]  rd_addr_o;
   logic [31:0] wr_data_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sparrow_wb_arbiter #(.MAX_WAIT(4), .WAIT_W(3)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_valid_i(a_valid_i), .a_rd_i(a_rd_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
      .b_valid_i(b_valid_i), .b_rd_i(b_rd_i), .b_data_i(b_data_i), .b_ready_o(b_ready_o),
      .iss_valid_i(iss_valid_i), .iss_rd_i(iss_rd_i), .iss_ready_o(iss_ready_o),
      .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .hazard_o(hazard_o),
      .wr_en_o(wr_en_o), .rd_addr_o(rd_addr_o), .wr_data_o(wr_data_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      a_valid_i = 0; a_rd_i = 0; a_data_i = 0;
      b_valid_i = 0; b_rd_i = 0; b_data_i = 0;
      iss_valid_i = 0; iss_rd_i = 0;
      rs1_addr_i = 0; rs2_addr_i = 0;
   endtask

   initial begin
      logic exp_a [6];
      logic exp_b [6];
      exp_a = '{1, 1, 1, 1, 0, 1};
      exp_b = '{0, 0, 0, 0, 1, 0};

      // Reset state
      idle_inputs();
      reset_n = 0;
      step(); step();
      chk("rst_wr_en", 32'(wr_en_o), 32'd0);
      chk("rst_rd_addr", 32'(rd_addr_o), 32'd0);
      chk("rst_wr_data", wr_data_o, 32'd0);
      chk("rst_hazard", 32'(hazard_o), 32'd0);
      chk("rst_iss_ready", 32'(iss_ready_o), 32'd1);
      reset_n = 1;
      step();

      // 1: A only
      a_valid_i = 1; a_rd_i = 5; a_data_i = 32'hDEADBEEF;
      #1;
      chk("t1_a_ready", 32'(a_ready_o), 32'd1);
      chk("t1_b_ready", 32'(b_ready_o), 32'd0);
      step();
      a_valid_i = 0;
      chk("t1_wr_en", 32'(wr_en_o), 32'd1);
      chk("t1_rd_addr", 32'(rd_addr_o), 32'd5);
      chk("t1_wr_data", wr_data_o, 32'hDEADBEEF);
      step();
      chk("t1_wr_en_drop", 32'(wr_en_o), 32'd0);
      chk("t1_rd_hold", 32'(rd_addr_o), 32'd5);
      chk("t1_data_hold", wr_data_o, 32'hDEADBEEF);

      // 2: contention, A wins 4 cycles then B once then A
      a_valid_i = 1; a_rd_i = 1;
      b_valid_i = 1; b_rd_i = 2; b_data_i = 32'h200;
      for (int i = 0; i < 6; i++) begin
         a_data_i = 32'h100 + 32'(i);
         #1;
         chk($sformatf("t2_a_ready_%0d", i), 32'(a_ready_o), 32'(exp_a[i]));
         chk($sformatf("t2_b_ready_%0d", i), 32'(b_ready_o), 32'(exp_b[i]));
         step();
         chk($sformatf("t2_wr_data_%0d", i), wr_data_o,
             exp_b[i] ? 32'h200 : 32'h100 + 32'(i));
         chk($sformatf("t2_rd_addr_%0d", i), 32'(rd_addr_o), exp_b[i] ? 32'd2 : 32'd1);
      end
      idle_inputs();
      step();

      // 3: scoreboard RAW
      iss_valid_i = 1; iss_rd_i = 7;
      #1;
      chk("t3_iss_ready", 32'(iss_ready_o), 32'd1);
      step();
      iss_valid_i = 0; rs1_addr_i = 7;
      #1;
      chk("t3_hazard_set", 32'(hazard_o), 32'd1);
      b_valid_i = 1; b_rd_i = 7; b_data_i = 32'h77;
      #1;
      chk("t3_b_ready", 32'(b_ready_o), 32'd1);
      step();
      b_valid_i = 0;
      #1;
      chk("t3_wr_en", 32'(wr_en_o), 32'd1);
      chk("t3_rd_addr", 32'(rd_addr_o), 32'd7);
      chk("t3_hazard_clr", 32'(hazard_o), 32'd0);
      rs1_addr_i = 0;

      // 4: WAW
      iss_valid_i = 1; iss_rd_i = 9;
      step();
      iss_valid_i = 0;
      #1;
      chk("t4_iss_ready_9", 32'(iss_ready_o), 32'd0);
      iss_rd_i = 10;
      #1;
      chk("t4_iss_ready_10", 32'(iss_ready_o), 32'd1);

      // 5: x0 writes and issues
      b_valid_i = 1; b_rd_i = 0; b_data_i = 32'h55;
      #1;
      chk("t5_b_ready", 32'(b_ready_o), 32'd1);
      step();
      b_valid_i = 0;
      chk("t5_wr_en", 32'(wr_en_o), 32'd0);
      iss_valid_i = 1; iss_rd_i = 0;
      step();
      iss_valid_i = 0;
      #1;
      chk("t5_hazard_x0", 32'(hazard_o), 32'd0);
      chk("t5_iss_ready_x0", 32'(iss_ready_o), 32'd1);

      // Same-cycle set and clear of one index: set wins
      iss_valid_i = 1; iss_rd_i = 12;
      b_valid_i = 1; b_rd_i = 12; b_data_i = 32'hC;
      step();
      iss_valid_i = 0; b_valid_i = 0; rs2_addr_i = 12;
      #1;
      chk("set_wins_hazard", 32'(hazard_o), 32'd1);
      rs2_addr_i = 0;

      // 6: reset mid-operation
      iss_valid_i = 1; iss_rd_i = 3;
      step();
      iss_rd_i = 4;
      step();
      iss_valid_i = 0;
      a_valid_i = 1; a_rd_i = 20; a_data_i = 32'hA5;
      b_valid_i = 1; b_rd_i = 21; b_data_i = 32'hB5;
      step(); step();
      rs1_addr_i = 3; rs2_addr_i = 4;
      #1;
      chk("t6_hazard_pre", 32'(hazard_o), 32'd1);
      reset_n = 0;
      #1;
      chk("t6_wr_en", 32'(wr_en_o), 32'd0);
      chk("t6_rd_addr", 32'(rd_addr_o), 32'd0);
      chk("t6_wr_data", wr_data_o, 32'd0);
      chk("t6_hazard", 32'(hazard_o), 32'd0);
      idle_inputs();
      step();
      reset_n = 1;
      step();

      // Wait counter restarted from zero after reset
      a_valid_i = 1; a_rd_i = 1;
      b_valid_i = 1; b_rd_i = 2;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("t6_b_ready_%0d", i), 32'(b_ready_o), 32'(exp_b[i]));
         step();
      end
      idle_inputs();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
